// File: rtl/layered_color_mapper.sv
// layered_color_mapper: priority sprite-layer colour select with frame-timed fade, 2-stage pipeline
module layered_color_mapper #(
  parameter int NUM_LAYERS = 4,
  parameter logic [23:0] BG_COLOR = 24'h00FF00,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF,
  parameter int BLINK_BIT = 3
) (
  input  logic Clk,
  input  logic Reset,
  input  logic pixel_valid,
  input  logic frame_start,
  input  logic [NUM_LAYERS-1:0] layer_hit,
  input  logic [24*NUM_LAYERS-1:0] layer_rgb,
  input  logic [NUM_LAYERS-1:0] blink_mask,
  input  logic fade_out_req,
  input  logic fade_in_req,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic out_valid,
  output logic fade_busy
);
  typedef enum logic [1:0] {IDLE, FADING_OUT, DARK, FADING_IN} state_t;
  state_t state, state_n;
  logic [3:0] level, level_n;
  logic [7:0] frame_cnt;
  logic [23:0] pick, s1_rgb;
  logic s1_valid;
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [3:0] l);
    return 8'(({4'd0, c} * {8'd0, l}) >> 3);
  endfunction
  // walk from the highest index down so the lowest visible layer wins
  always_comb begin
    pick = BG_COLOR;
    for (int i = NUM_LAYERS - 1; i >= 0; i--)
      if (layer_hit[i] && layer_rgb[24*i +: 24] != KEY_COLOR && !(blink_mask[i] && frame_cnt[BLINK_BIT]))
        pick = layer_rgb[24*i +: 24];
  end
  // a reversing request takes precedence over a frame step in the same cycle
  always_comb begin
    state_n = state;
    level_n = level;
    case (state)
      IDLE: state_n = fade_out_req ? FADING_OUT : IDLE;
      FADING_OUT:
        if (fade_in_req && !fade_out_req) state_n = FADING_IN;
        else if (frame_start) begin
          level_n = level == 4'd0 ? 4'd0 : level - 4'd1;
          state_n = level <= 4'd1 ? DARK : FADING_OUT;
        end
      DARK: state_n = fade_in_req ? FADING_IN : DARK;
      FADING_IN:
        if (fade_out_req) state_n = FADING_OUT;
        else if (frame_start) begin
          level_n = level >= 4'd8 ? 4'd8 : level + 4'd1;
          state_n = level >= 4'd7 ? IDLE : FADING_IN;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      level <= 4'd8;
      frame_cnt <= '0;
      s1_rgb <= '0;
      s1_valid <= 1'b0;
      Red <= '0;
      Green <= '0;
      Blue <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      level <= level_n;
      frame_cnt <= frame_cnt + 8'(frame_start);
      s1_rgb <= pick;
      s1_valid <= pixel_valid;
      Red <= s1_valid ? scale(s1_rgb[23:16], level) : '0;
      Green <= s1_valid ? scale(s1_rgb[15:8], level) : '0;
      Blue <= s1_valid ? scale(s1_rgb[7:0], level) : '0;
      out_valid <= s1_valid;
    end
  end
  assign fade_busy = state == FADING_OUT || state == FADING_IN;
endmodule

// File: tb/tb_layered_color_mapper.sv
// tb_layered_color_mapper: scoreboard bench with a behavioural colour/fade model
module tb_layered_color_mapper;
  localparam int NL = 4;
  localparam logic [23:0] BG = 24'h00FF00;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam int BB = 3;
  logic clk = 0, rst = 1, pixel_valid = 0, frame_start = 0, fade_out_req = 0, fade_in_req = 0;
  logic [NL-1:0] layer_hit = '0, blink_mask = '0;
  logic [24*NL-1:0] layer_rgb = '0;
  logic [7:0] red, green, blue;
  logic out_valid, fade_busy;
  typedef struct {logic [23:0] rgb; int cyc;} exp_t;
  exp_t sb[$];
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [7:0] m_fc = 0;
  logic [3:0] m_lvl = 8;
  int m_st = 0;
  layered_color_mapper #(.NUM_LAYERS(NL), .BG_COLOR(BG), .KEY_COLOR(KEY), .BLINK_BIT(BB)) dut (
    .Clk(clk), .Reset(rst), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .layer_hit(layer_hit), .layer_rgb(layer_rgb), .blink_mask(blink_mask),
    .fade_out_req(fade_out_req), .fade_in_req(fade_in_req),
    .Red(red), .Green(green), .Blue(blue), .out_valid(out_valid), .fade_busy(fade_busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [7:0] dim(input logic [7:0] c, input logic [3:0] l);
    return 8'((32'(c) * 32'(l)) / 8);
  endfunction
  function automatic logic [23:0] pick_model();
    logic [23:0] r;
    bit found;
    r = BG;
    found = 0;
    for (int i = 0; i < NL; i++)
      if (!found && layer_hit[i] && layer_rgb[24*i +: 24] != KEY && !(blink_mask[i] && m_fc[BB])) begin
        r = layer_rgb[24*i +: 24];
        found = 1;
      end
    return r;
  endfunction
  // model states: 0 idle, 1 fading out, 2 dark, 3 fading in
  task automatic step();
    logic [23:0] s;
    exp_t e;
    s = pick_model();
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_fc = 0; m_lvl = 8; m_st = 0;
      sb.delete();
    end else begin
      if (frame_start) m_fc++;
      if (fade_out_req && (m_st == 0 || m_st == 3)) m_st = 1;
      else if (fade_in_req && m_st == 2) m_st = 3;
      else if (fade_in_req && !fade_out_req && m_st == 1) m_st = 3;
      else if (frame_start && m_st == 1) begin
        if (m_lvl > 0) m_lvl--;
        if (m_lvl == 0) m_st = 2;
      end else if (frame_start && m_st == 3) begin
        if (m_lvl < 8) m_lvl++;
        if (m_lvl == 8) m_st = 0;
      end
      if (pixel_valid) begin
        e.rgb = {dim(s[23:16], m_lvl), dim(s[15:8], m_lvl), dim(s[7:0], m_lvl)};
        e.cyc = cyc;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    if (out_valid) begin
      if (sb.size() == 0) check("valid_without_pixel", out_valid, 0);
      else begin
        e = sb.pop_front();
        check("latency", cyc, e.cyc + 1);
        check("rgb", {red, green, blue}, e.rgb);
      end
    end else check("blank_rgb", {red, green, blue}, 0);
    check("fade_busy", fade_busy, m_st == 1 || m_st == 3);
  endtask
  task automatic idle(input int n);
    pixel_valid = 0; frame_start = 0; fade_out_req = 0; fade_in_req = 0;
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_start = 1; step();
      frame_start = 0; step();
    end
  endtask
  task automatic px(input string tag, input logic [NL-1:0] h, input logic [24*NL-1:0] rgb, input logic [23:0] want);
    layer_hit = h; layer_rgb = rgb; pixel_valid = 1;
    step();
    pixel_valid = 0;
    step();
    check(tag, {out_valid, red, green, blue}, {1'b1, want});
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      frame_start = 1; fade_out_req = 1; pixel_valid = 1;
      step();
    end
    rst = 0;
    idle(2);
    px("two_hits", 4'b0110, {24'h0, 24'hABCDEF, 24'h123456, 24'h0}, 24'h123456);
    px("key_skip", 4'b0011, {24'h0, 24'h0, 24'h0000FF, KEY}, 24'h0000FF);
    px("no_hit", 4'b0000, {24'h0, 24'h0, 24'h0000FF, KEY}, BG);
    px("top_layer", 4'b1111, {24'h111111, 24'h222222, 24'h333333, 24'h444444}, 24'h444444);
    px("last_layer", 4'b1000, {24'h010203, 24'h222222, 24'h333333, 24'h444444}, 24'h010203);
    blink_mask = 4'b0001;
    frames(8);
    px("blink_off", 4'b0001, {72'h0, 24'hFFFFFF}, BG);
    frames(8);
    px("blink_on", 4'b0001, {72'h0, 24'hFFFFFF}, 24'hFFFFFF);
    blink_mask = 0;
    fade_in_req = 1; step(); fade_in_req = 0;
    check("idle_ignores_in", fade_busy, 0);
    fade_out_req = 1; step(); fade_out_req = 0;
    frames(4);
    px("half_level", 4'b0001, {72'h0, 24'hFF8040}, 24'h7F4020);
    frames(4);
    px("dark", 4'b0001, {72'h0, 24'hFF8040}, 24'h000000);
    check("dark_busy", fade_busy, 0);
    fade_in_req = 1; step(); fade_in_req = 0;
    frames(2);
    px("fade_in_2", 4'b0001, {72'h0, 24'h808080}, 24'h202020);
    fade_out_req = 1; fade_in_req = 1; step(); fade_out_req = 0; fade_in_req = 0;
    frames(1);
    px("reverse_out", 4'b0001, {72'h0, 24'h808080}, 24'h101010);
    for (int i = 0; i < 300; i++) begin
      pixel_valid = 1'($urandom_range(0, 1));
      layer_hit = NL'($urandom);
      blink_mask = NL'($urandom);
      for (int j = 0; j < NL; j++) layer_rgb[24*j +: 24] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
      frame_start = $urandom_range(0, 3) == 0;
      fade_out_req = $urandom_range(0, 15) == 0;
      fade_in_req = $urandom_range(0, 15) == 0;
      step();
    end
    idle(2);
    rst = 1; step(); rst = 0;
    blink_mask = 0;
    fade_out_req = 1; fade_in_req = 1; step(); fade_out_req = 0; fade_in_req = 0;
    check("both_req_busy", fade_busy, 1);
    frames(5);
    px("level_3", 4'b0001, {72'h0, 24'hFF8040}, 24'h5F3018);
    layer_hit = 4'b0001; layer_rgb = {72'h0, 24'hFFFFFF}; pixel_valid = 1;
    rst = 1; step(); step(); rst = 0;
    check("reset_busy", fade_busy, 0);
    px("after_reset", 4'b0001, {72'h0, 24'hFFFFFF}, 24'hFFFFFF);
    idle(3);
    check("drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/layered_color_mapper.md
LAYERED_COLOR_MAPPER -- requirements
Module: layered_color_mapper

Interface
REQ-001 The block SHALL have a parameter NUM_LAYERS, default 4, giving the sprite layer count (1..8); layer 0 has highest priority.
REQ-002 The block SHALL have a parameter BG_COLOR, default 24'h00FF00, giving the RGB emitted when no layer is visible.
REQ-003 The block SHALL have a parameter KEY_COLOR, default 24'hFF00FF, giving the RGB value treated as transparent.
REQ-004 The block SHALL have a parameter BLINK_BIT, default 3, giving the frame counter bit that gates blinking layers.
REQ-005 Clk  input  1  system clock; all state changes on rising edge.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 pixel_valid  input  1  current inputs describe a visible pixel.
REQ-008 frame_start  input  1  one-cycle pulse, once per frame.
REQ-009 layer_hit  input  NUM_LAYERS  bit i: layer i covers the pixel.
REQ-010 layer_rgb  input  24*NUM_LAYERS  layer i RGB at bits [24i+23:24i], R in the MSBs.
REQ-011 blink_mask  input  NUM_LAYERS  bit i: layer i blinks.
REQ-012 fade_out_req, fade_in_req  input  1 each  one-cycle fade command pulses.
REQ-013 Red, Green, Blue  output  8 each  registered pixel colour.
REQ-014 out_valid  output  1  Red/Green/Blue correspond to a valid pixel.
REQ-015 fade_busy  output  1  high in FADING_OUT or FADING_IN.

Function
REQ-016 The block SHALL be a 2-stage pipeline; the inputs sampled at edge N SHALL appear on the outputs after edge N+1, and out_valid SHALL equal pixel_valid delayed by 2 cycles.
REQ-017 Stage 1 SHALL register layer_rgb and pixel_valid together with an effective hit vector: hit_i = layer_hit[i] AND layer_rgb_i != KEY_COLOR AND NOT (blink_mask[i] AND frame_cnt[BLINK_BIT]).
REQ-018 Stage 1 SHALL select the lowest-index layer with its effective hit bit set; if no bit is set, it SHALL select BG_COLOR.
REQ-019 Stage 2 SHALL compute each output channel as (c * level) >> 3, with an unsigned 12-bit intermediate product and level in 0..8; level 8 SHALL pass c unchanged and level 0 SHALL yield 0.
REQ-020 When stage 2 holds an invalid pixel, Red/Green/Blue SHALL be driven to 0.
REQ-021 frame_cnt SHALL be an 8-bit counter that increments on frame_start and wraps from 255 to 0.
REQ-022 The fade FSM SHALL have four states: IDLE (level 8), FADING_OUT, DARK (level 0) and FADING_IN.
REQ-023 From IDLE, fade_out_req SHALL move the FSM to FADING_OUT, and fade_in_req SHALL be ignored.
REQ-024 In FADING_OUT, level SHALL decrement by 1 on each frame_start, and the FSM SHALL enter DARK in the same cycle that level becomes 0.
REQ-025 From DARK, fade_in_req SHALL move the FSM to FADING_IN, and fade_out_req SHALL be ignored.
REQ-026 In FADING_IN, level SHALL increment by 1 on each frame_start, and the FSM SHALL enter IDLE in the same cycle that level becomes 8.
REQ-027 A request opposite to the current fade direction SHALL reverse the direction immediately without changing level; if both requests arrive in the same cycle, fade_out_req SHALL win.
REQ-028 A level change SHALL take effect on the pixel that enters stage 2 in the cycle after the frame_start edge; level SHALL never leave 0..8.

Reset
REQ-029 While Reset is high, all pipeline registers, Red/Green/Blue, out_valid and fade_busy SHALL be 0, frame_cnt SHALL be 0, the FSM SHALL be IDLE and level SHALL be 8.
REQ-030 Reset mid-fade SHALL abandon the fade, and the first valid pixel after reset SHALL appear at full brightness.
REQ-031 While Reset is high, frame_start and fade requests SHALL be ignored.

Verification
REQ-032 layer_hit=4'b0110, layer1=24'h123456, layer2=24'hABCDEF, level 8 -> two cycles later Red/Green/Blue = 12/34/56 and out_valid=1.
REQ-033 layer_hit=4'b0011 with layer0=KEY_COLOR, layer1=24'h0000FF -> output 00/00/FF; with layer_hit=0 -> output 00/FF/00.
REQ-034 blink_mask=4'b0001, layer0 hit with colour 24'hFFFFFF, 8 frame_start pulses -> frame_cnt=8 and the pixel shows BG; after 16 pulses (frame_cnt=16, bit 3 clear) -> the pixel shows FFFFFF.
REQ-035 fade_out_req, then 4 frame_start pulses, colour 24'hFF8040 -> level 4, output 7F/40/20; after 8 pulses -> state DARK, output 00/00/00, fade_busy=0.
REQ-036 fade_out_req and fade_in_req asserted together in IDLE -> state FADING_OUT; Reset asserted at level 3 -> state IDLE, level 8, outputs 0 until out_valid returns.
